return_address_stack_rc: RTL and testbench
==========================================

Name: return_address_stack_rc

Overview:
- Next-generation return address stack for the IF-stage branch predictor: parametrised depth, per-entry recursion counters, selectable overflow policy, and full-entry checkpoint repair.
- Consecutive pushes of the same link address (direct recursion) share one entry and increment its counter instead of consuming new slots.
- Each checkpoint carries the top entry's address and counter as well as the pointers, so EX-stage recovery also repairs an entry overwritten on the wrong path.
- Prediction lookup is combinational; all stack updates are registered.

Parameters:
- RAS_DEPTH, 16, number of entries (power of two, >=2).
- RAS_PTR_BITS, $clog2(RAS_DEPTH), TOS pointer width.
- CNT_BITS, 3, recursion counter width per entry; max repeat = 2^CNT_BITS-1.
- OVERFLOW_MODE, 0, 0 = wrap (push when full overwrites oldest); 1 = saturate (push when full is dropped).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_stall  in  1  hold state; push/pop ignored
- i_push  in  1  call detected (already decoded and qualified upstream)
- i_pop  in  1  return detected and prediction allowed
- i_link_address  in  riscv_pkg::XLEN  address to push
- i_restore  in  1  misprediction recovery; highest priority
- i_restore_tos  in  RAS_PTR_BITS  checkpointed TOS
- i_restore_valid_count  in  RAS_PTR_BITS+1  checkpointed occupancy
- i_restore_top_addr  in  riscv_pkg::XLEN  checkpointed ras_stack[tos]
- i_restore_top_cnt  in  CNT_BITS  checkpointed cnt[tos]
- o_ras_valid  out  1  valid_count != 0
- o_ras_target  out  riscv_pkg::XLEN  ras_stack[tos]
- o_ckpt_tos  out  RAS_PTR_BITS  current tos
- o_ckpt_valid_count  out  RAS_PTR_BITS+1  current valid_count
- o_ckpt_top_addr  out  riscv_pkg::XLEN  current ras_stack[tos]
- o_ckpt_top_cnt  out  CNT_BITS  current cnt[tos]
- o_overflow  out  1  one-cycle pulse: push lost or oldest entry overwritten
- o_underflow  out  1  one-cycle pulse: pop requested on empty stack

Behaviour:
- Reset: tos=0, valid_count=0, all cnt=0, o_overflow=0, o_underflow=0. Stack address storage is not reset. After reset o_ras_valid=0 and the o_ckpt_* outputs reflect reset state.
- Outputs o_ras_* and o_ckpt_* are combinational from current state, i.e. state before this cycle's operation. Updates are visible the next cycle.
- Priority each cycle: i_rst > i_restore > i_stall > operation. o_overflow and o_underflow are registered and are 0 in any cycle after rst, restore or stall.
- Restore:
  - tos <= i_restore_tos; valid_count <= i_restore_valid_count.
  - ras_stack[i_restore_tos] <= i_restore_top_addr; cnt[i_restore_tos] <= i_restore_top_cnt.
  - Applied even while stalled. Concurrent push/pop is discarded.
- Push only (i_push && !i_pop):
  - Recursion: if valid_count!=0, i_link_address==ras_stack[tos] and cnt[tos]!=max, then cnt[tos]++. tos and valid_count are unchanged.
  - Otherwise, not full: write entry tos+1 (mod RAS_DEPTH) = link with cnt 0, tos++, valid_count++.
  - Full, mode 0: same write, tos wraps, valid_count stays RAS_DEPTH, o_overflow=1.
  - Full, mode 1: no state change, o_overflow=1.
  - A match with cnt[tos]==max takes the normal push path.
- Pop only (i_pop && !i_push):
  - Empty: no change, o_underflow=1.
  - cnt[tos]!=0: cnt[tos]--. tos and valid_count are unchanged.
  - Otherwise: tos-- (wraps 0 -> RAS_DEPTH-1), valid_count--.
- Both asserted (coroutine):
  - Empty: behaves as push.
  - cnt[tos]==0: ras_stack[tos] <= link, cnt[tos] stays 0, pointers unchanged.
  - cnt[tos]!=0: cnt[tos]--, then normal push of link into tos+1, applying the full/overflow rules. The recursion match is not applied in this case.
- Arithmetic: pointer arithmetic is modulo RAS_DEPTH. valid_count is never above RAS_DEPTH and never decrements below 0. Counters saturate at max on the increment path only.
- Occupancy semantics: valid_count counts slots, not logical returns. Logical depth = sum over valid slots of (cnt+1).

Test Plan:
- Reset, then push 0x100, 0x200, pop -> o_ras_target=0x200 before the pop; after: tos=1, target=0x100, valid_count=1.
- Push 0x400 five times with CNT_BITS=3 -> valid_count=1, cnt=4. Five pops return 0x400 each; sixth pop -> o_underflow=1, o_ras_valid=0.
- RAS_DEPTH=4, mode 0: push 0x10, 0x20, 0x30, 0x40, 0x50 -> o_overflow=1 on the 5th, valid_count=4, target=0x50. Four pops yield 0x50, 0x40, 0x30, 0x20. Repeat with mode 1 -> 5th push dropped, target stays 0x40.
- Record the o_ckpt_* values, then do push 0x700, coroutine with 0x800, pop, pop. Assert i_restore with the recorded values -> next cycle tos, valid_count, target and cnt equal the checkpoint exactly, including the overwritten top entry.
- Same cycle i_restore=1 and i_push=1 with i_stall=1 -> only the restore takes effect. i_rst asserted mid-sequence at valid_count=3 -> next cycle valid_count=0, o_ras_valid=0.
- Coroutine on top cnt=2 (addr 0x900) with link 0xA00 -> cnt[old tos]=1, new top=0xA00, valid_count+1. A pop then returns 0x900 twice.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - core-wide constants shared by front-end blocks
package riscv_pkg;
  parameter int XLEN = 32;
endpackage

// File: rtl/return_address_stack_rc.sv
// rtl/return_address_stack_rc.sv - return address stack with recursion counters and full-entry checkpoint repair
module return_address_stack_rc #(
  parameter int RAS_DEPTH     = 16,
  parameter int RAS_PTR_BITS  = $clog2(RAS_DEPTH),
  parameter int CNT_BITS      = 3,
  parameter int OVERFLOW_MODE = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_stall,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [riscv_pkg::XLEN-1:0] i_link_address,
  input  logic                       i_restore,
  input  logic [RAS_PTR_BITS-1:0]    i_restore_tos,
  input  logic [RAS_PTR_BITS:0]      i_restore_valid_count,
  input  logic [riscv_pkg::XLEN-1:0] i_restore_top_addr,
  input  logic [CNT_BITS-1:0]        i_restore_top_cnt,
  output logic                       o_ras_valid,
  output logic [riscv_pkg::XLEN-1:0] o_ras_target,
  output logic [RAS_PTR_BITS-1:0]    o_ckpt_tos,
  output logic [RAS_PTR_BITS:0]      o_ckpt_valid_count,
  output logic [riscv_pkg::XLEN-1:0] o_ckpt_top_addr,
  output logic [CNT_BITS-1:0]        o_ckpt_top_cnt,
  output logic                       o_overflow,
  output logic                       o_underflow
);
  localparam int XLEN = riscv_pkg::XLEN;
  localparam logic [CNT_BITS-1:0]   CNT_MAX   = '1;
  localparam logic [RAS_PTR_BITS:0] DEPTH_CNT = (RAS_PTR_BITS+1)'(RAS_DEPTH);

  logic [XLEN-1:0]         r_stack [RAS_DEPTH];
  logic [CNT_BITS-1:0]     r_cnt   [RAS_DEPTH];
  logic [RAS_PTR_BITS-1:0] r_tos;
  logic [RAS_PTR_BITS:0]   r_valid_count;
  logic                    r_overflow;
  logic                    r_underflow;

  logic [XLEN-1:0]         w_top_addr;
  logic [CNT_BITS-1:0]     w_top_cnt;
  logic                    w_empty;
  logic                    w_full;
  logic [RAS_PTR_BITS-1:0] w_tos_inc;
  logic [RAS_PTR_BITS-1:0] w_tos_dec;
  logic                    w_op_push;
  logic                    w_op_pop;
  logic                    w_op_both;
  logic                    w_push_req;
  logic                    w_recur;
  logic                    w_co_keep;
  logic                    w_co_dec;
  logic                    w_norm_push;

  logic [RAS_PTR_BITS-1:0] w_nxt_tos;
  logic [RAS_PTR_BITS:0]   w_nxt_vc;
  logic                    w_stk_we;
  logic [RAS_PTR_BITS-1:0] w_stk_idx;
  logic [XLEN-1:0]         w_stk_data;
  logic                    w_cnt_we;
  logic [RAS_PTR_BITS-1:0] w_cnt_idx;
  logic [CNT_BITS-1:0]     w_cnt_data;
  logic                    w_clr_we;
  logic                    w_nxt_ovf;
  logic                    w_nxt_unf;

  assign w_top_addr = r_stack[r_tos];
  assign w_top_cnt  = r_cnt[r_tos];
  assign w_empty    = (r_valid_count == '0);
  assign w_full     = (r_valid_count == DEPTH_CNT);
  assign w_tos_inc  = r_tos + 1'b1;
  assign w_tos_dec  = r_tos - 1'b1;

  assign w_op_push  = i_push && !i_pop;
  assign w_op_pop   = i_pop && !i_push;
  assign w_op_both  = i_push && i_pop;

  // A coroutine on an empty stack degenerates to a plain push.
  assign w_push_req  = w_op_push || (w_op_both && w_empty);
  assign w_recur     = w_push_req && !w_empty && (i_link_address == w_top_addr) && (w_top_cnt != CNT_MAX);
  assign w_co_keep   = w_op_both && !w_empty && (w_top_cnt == '0);
  assign w_co_dec    = w_op_both && !w_empty && (w_top_cnt != '0);
  assign w_norm_push = (w_push_req && !w_recur) || w_co_dec;

  always_comb begin
    w_nxt_tos  = r_tos;
    w_nxt_vc   = r_valid_count;
    w_stk_we   = 1'b0;
    w_stk_idx  = r_tos;
    w_stk_data = i_link_address;
    w_cnt_we   = 1'b0;
    w_cnt_idx  = r_tos;
    w_cnt_data = w_top_cnt;
    w_clr_we   = 1'b0;
    w_nxt_ovf  = 1'b0;
    w_nxt_unf  = 1'b0;
    if (!i_rst) begin
      if (i_restore) begin
        w_nxt_tos  = i_restore_tos;
        w_nxt_vc   = i_restore_valid_count;
        w_stk_we   = 1'b1;
        w_stk_idx  = i_restore_tos;
        w_stk_data = i_restore_top_addr;
        w_cnt_we   = 1'b1;
        w_cnt_idx  = i_restore_tos;
        w_cnt_data = i_restore_top_cnt;
      end else if (!i_stall) begin
        if (w_recur) begin
          w_cnt_we   = 1'b1;
          w_cnt_data = w_top_cnt + 1'b1;
        end
        if (w_co_dec) begin
          w_cnt_we   = 1'b1;
          w_cnt_data = w_top_cnt - 1'b1;
        end
        if (w_co_keep) begin
          w_stk_we = 1'b1;
        end
        if (w_norm_push) begin
          w_nxt_ovf = w_full;
          if (!(w_full && OVERFLOW_MODE == 1)) begin
            w_stk_we  = 1'b1;
            w_stk_idx = w_tos_inc;
            w_clr_we  = 1'b1;
            w_nxt_tos = w_tos_inc;
            if (!w_full) w_nxt_vc = r_valid_count + 1'b1;
          end
        end
        if (w_op_pop) begin
          if (w_empty) begin
            w_nxt_unf = 1'b1;
          end else if (w_top_cnt != '0) begin
            w_cnt_we   = 1'b1;
            w_cnt_data = w_top_cnt - 1'b1;
          end else begin
            w_nxt_tos = w_tos_dec;
            w_nxt_vc  = r_valid_count - 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tos         <= '0;
      r_valid_count <= '0;
      r_overflow    <= 1'b0;
      r_underflow   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) r_cnt[i] <= '0;
    end else begin
      r_tos         <= w_nxt_tos;
      r_valid_count <= w_nxt_vc;
      r_overflow    <= w_nxt_ovf;
      r_underflow   <= w_nxt_unf;
      if (w_cnt_we) r_cnt[w_cnt_idx] <= w_cnt_data;
      if (w_clr_we) r_cnt[w_tos_inc] <= '0;
    end
  end

  // Address storage carries no reset; occupancy alone marks entries live.
  always_ff @(posedge i_clk) begin
    if (w_stk_we) r_stack[w_stk_idx] <= w_stk_data;
  end

  assign o_ras_valid        = !w_empty;
  assign o_ras_target       = w_top_addr;
  assign o_ckpt_tos         = r_tos;
  assign o_ckpt_valid_count = r_valid_count;
  assign o_ckpt_top_addr    = w_top_addr;
  assign o_ckpt_top_cnt     = w_top_cnt;
  assign o_overflow         = r_overflow;
  assign o_underflow        = r_underflow;
endmodule

// File: tb/tb_return_address_stack_rc.sv
// tb/tb_return_address_stack_rc.sv - scoreboard bench for return_address_stack_rc, wrap and saturate variants
module tb_return_address_stack_rc;
  localparam int D = 4;
  localparam int CMAX = 7;

  typedef struct {
    bit          valid;
    bit          known;
    logic [31:0] addr;
    int          tos;
    int          vc;
    int          cnt;
    bit          ovf;
    bit          unf;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst, restore, stall, push, pop;
  logic [31:0] link;
  logic [1:0]  rs_tos  [2];
  logic [2:0]  rs_vc   [2];
  logic [31:0] rs_addr [2];
  logic [2:0]  rs_cnt  [2];
  logic        o_valid [2];
  logic [31:0] o_target[2];
  logic [1:0]  o_tos   [2];
  logic [2:0]  o_vc    [2];
  logic [31:0] o_taddr [2];
  logic [2:0]  o_tcnt  [2];
  logic        o_ovf   [2];
  logic        o_unf   [2];

  int checks = 0;
  int errors = 0;

  // Reference model: per-variant circular stack with explicit counters.
  int          mtos[2], mvc[2];
  int          mcnt[2][D];
  logic [31:0] mstk[2][D];
  bit          mknown[2][D];
  bit          movf[2], munf[2];
  int          ck_tos[2], ck_vc[2], ck_cnt[2];
  logic [31:0] ck_addr[2];
  snap_t       q0[$];
  snap_t       q1[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    return_address_stack_rc #(.RAS_DEPTH(D), .CNT_BITS(3), .OVERFLOW_MODE(g)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_push(push), .i_pop(pop),
      .i_link_address(link), .i_restore(restore),
      .i_restore_tos(rs_tos[g]), .i_restore_valid_count(rs_vc[g]),
      .i_restore_top_addr(rs_addr[g]), .i_restore_top_cnt(rs_cnt[g]),
      .o_ras_valid(o_valid[g]), .o_ras_target(o_target[g]),
      .o_ckpt_tos(o_tos[g]), .o_ckpt_valid_count(o_vc[g]),
      .o_ckpt_top_addr(o_taddr[g]), .o_ckpt_top_cnt(o_tcnt[g]),
      .o_overflow(o_ovf[g]), .o_underflow(o_unf[g]));
  end

  task automatic chk(string nm, int m, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", nm, m, act, exp, $time);
    end
  endtask

  task automatic cmp(int m, snap_t e);
    chk("ras_valid", m, 32'(o_valid[m]), 32'(e.valid));
    chk("ckpt_tos", m, 32'(o_tos[m]), 32'(e.tos));
    chk("ckpt_valid_count", m, 32'(o_vc[m]), 32'(e.vc));
    chk("ckpt_top_cnt", m, 32'(o_tcnt[m]), 32'(e.cnt));
    chk("overflow", m, 32'(o_ovf[m]), 32'(e.ovf));
    chk("underflow", m, 32'(o_unf[m]), 32'(e.unf));
    if (e.known) begin
      chk("ras_target", m, o_target[m], e.addr);
      chk("ckpt_top_addr", m, o_taddr[m], e.addr);
    end
  endtask

  always @(negedge clk) begin : mon
    snap_t e;
    if (q0.size() > 0) begin e = q0.pop_front(); cmp(0, e); end
    if (q1.size() > 0) begin e = q1.pop_front(); cmp(1, e); end
  end

  function automatic snap_t snap(int m);
    snap_t s;
    s.valid = (mvc[m] != 0);
    s.known = mknown[m][mtos[m]];
    s.addr  = mstk[m][mtos[m]];
    s.tos   = mtos[m];
    s.vc    = mvc[m];
    s.cnt   = mcnt[m][mtos[m]];
    s.ovf   = movf[m];
    s.unf   = munf[m];
    return s;
  endfunction

  task automatic m_push(int m, logic [31:0] ln, bit allow_rec);
    int t;
    bit full;
    if (allow_rec && mvc[m] > 0 && ln == mstk[m][mtos[m]] && mcnt[m][mtos[m]] < CMAX) begin
      mcnt[m][mtos[m]]++;
      return;
    end
    full = (mvc[m] == D);
    if (full) begin
      movf[m] = 1'b1;
      if (m == 1) return;
    end
    t = (mtos[m] + 1) % D;
    mstk[m][t] = ln;
    mcnt[m][t] = 0;
    mknown[m][t] = 1'b1;
    mtos[m] = t;
    if (!full) mvc[m]++;
  endtask

  task automatic m_apply(int m, bit r, bit rs, bit st, bit pu, bit po, logic [31:0] ln);
    movf[m] = 1'b0;
    munf[m] = 1'b0;
    if (r) begin
      mtos[m] = 0;
      mvc[m] = 0;
      for (int i = 0; i < D; i++) mcnt[m][i] = 0;
    end else if (rs) begin
      mtos[m] = ck_tos[m];
      mvc[m] = ck_vc[m];
      mstk[m][ck_tos[m]] = ck_addr[m];
      mcnt[m][ck_tos[m]] = ck_cnt[m];
      mknown[m][ck_tos[m]] = 1'b1;
    end else if (st) begin
    end else if (pu && !po) begin
      m_push(m, ln, 1'b1);
    end else if (po && !pu) begin
      if (mvc[m] == 0) munf[m] = 1'b1;
      else if (mcnt[m][mtos[m]] > 0) mcnt[m][mtos[m]]--;
      else begin
        mtos[m] = (mtos[m] + D - 1) % D;
        mvc[m]--;
      end
    end else if (pu && po) begin
      if (mvc[m] == 0) m_push(m, ln, 1'b1);
      else if (mcnt[m][mtos[m]] == 0) mstk[m][mtos[m]] = ln;
      else begin
        mcnt[m][mtos[m]]--;
        m_push(m, ln, 1'b0);
      end
    end
  endtask

  task automatic save_ckpt();
    for (int m = 0; m < 2; m++) begin
      ck_tos[m]  = mtos[m];
      ck_vc[m]   = mvc[m];
      ck_cnt[m]  = mcnt[m][mtos[m]];
      ck_addr[m] = mknown[m][mtos[m]] ? mstk[m][mtos[m]] : $urandom;
    end
  endtask

  task automatic step(bit r, bit rs, bit st, bit pu, bit po, logic [31:0] ln);
    rst = r; restore = rs; stall = st; push = pu; pop = po; link = ln;
    for (int m = 0; m < 2; m++) begin
      rs_tos[m]  = 2'(ck_tos[m]);
      rs_vc[m]   = 3'(ck_vc[m]);
      rs_addr[m] = ck_addr[m];
      rs_cnt[m]  = 3'(ck_cnt[m]);
    end
    q0.push_back(snap(0));
    q1.push_back(snap(1));
    for (int m = 0; m < 2; m++) m_apply(m, r, rs, st, pu, po, ln);
    @(posedge clk);
    #1;
  endtask

  task automatic do_rst();                  step(1, 0, 0, 0, 0, 32'h0); endtask
  task automatic do_push(logic [31:0] a);   step(0, 0, 0, 1, 0, a);     endtask
  task automatic do_pop();                  step(0, 0, 0, 0, 1, 32'h0); endtask
  task automatic do_both(logic [31:0] a);   step(0, 0, 0, 1, 1, a);     endtask
  task automatic do_idle();                 step(0, 0, 0, 0, 0, 32'h0); endtask
  task automatic do_restore();              step(0, 1, 0, 0, 0, 32'h0); endtask

  initial begin
    rst = 1'b1; restore = 1'b0; stall = 1'b0; push = 1'b0; pop = 1'b0; link = '0;
    for (int m = 0; m < 2; m++) begin
      mtos[m] = 0; mvc[m] = 0; movf[m] = 1'b0; munf[m] = 1'b0;
      for (int i = 0; i < D; i++) begin
        mcnt[m][i] = 0; mstk[m][i] = '0; mknown[m][i] = 1'b0;
      end
    end
    save_ckpt();
    repeat (2) @(posedge clk);
    #1;

    do_idle();
    do_push(32'h100); do_push(32'h200); do_pop(); do_idle();

    do_rst();
    repeat (5) do_push(32'h400);
    repeat (6) do_pop();
    do_idle();

    do_rst();
    repeat (9) do_push(32'h500);
    repeat (10) do_pop();

    do_rst();
    for (int i = 1; i <= 5; i++) do_push(32'(i * 16));
    repeat (4) do_pop();
    do_idle();

    do_rst();
    do_push(32'h600); do_push(32'h610);
    save_ckpt();
    do_push(32'h700); do_both(32'h800); do_pop(); do_pop(); do_push(32'h710);
    do_restore();
    do_idle();

    step(0, 1, 1, 1, 0, 32'h999);
    do_push(32'hB00);
    do_rst();
    do_idle();

    repeat (3) do_push(32'h900);
    do_both(32'hA00);
    repeat (4) do_pop();
    do_idle();

    do_rst();
    save_ckpt();
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 19) == 0) save_ckpt();
      step(r < 1, r >= 1 && r < 5, r >= 5 && r < 12,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           32'h100 + 32'($urandom_range(0, 3)) * 4);
    end
    do_idle();

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 0, 32'(q0.size() + q1.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
